// File: rtl/mp_add_sequencer.sv
//------------------------------------------------------------------------------
// mp_add_sequencer
//   Multi-cycle WIDTH-bit adder/subtractor.  A single SLICE-bit carry-skip
//   adder is reused for N = WIDTH/SLICE cycles, least significant slice first,
//   so every operation takes a fixed N cycles in RUN regardless of the data.
//
// Ports
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : request handshake (in_ready only while IDLE)
//   a, b, cin, sub      : operands, carry-in (add only), 1 = a - b
//   out_valid/out_ready : result handshake (result held until out_ready)
//   sum, cout, ovf      : result, carry out of MSB (sub: 1 = no borrow),
//                         two's-complement signed overflow
//   busy                : high whenever the sequencer is not IDLE
//------------------------------------------------------------------------------

// Combinational carry-skip adder: ripple inside each BLOCK_SIZE group, with the
// group carry bypassed when every bit of the group propagates.
module CarrySkipModule #(
  parameter int OPERAND_SIZE = 16,
  parameter int BLOCK_SIZE   = 4
) (
  input  logic [OPERAND_SIZE-1:0] a,
  input  logic [OPERAND_SIZE-1:0] b,
  input  logic                    cin,
  output logic [OPERAND_SIZE-1:0] sum,
  output logic                    cout
);
  localparam int NBLK = OPERAND_SIZE / BLOCK_SIZE;

  logic carry_s;
  logic blk_carry_s;
  logic prop_all_s;
  logic prop_s;

  // Ripple within each block, skip across a fully propagating block.
  always_comb begin
    sum         = {OPERAND_SIZE{1'b0}};
    carry_s     = cin;
    blk_carry_s = 1'b0;
    prop_all_s  = 1'b0;
    prop_s      = 1'b0;
    for (int blk = 0; blk < NBLK; blk++) begin
      blk_carry_s = carry_s;
      prop_all_s  = 1'b1;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        prop_s = a[blk*BLOCK_SIZE+i] ^ b[blk*BLOCK_SIZE+i];
        sum[blk*BLOCK_SIZE+i] = prop_s ^ blk_carry_s;
        blk_carry_s = (a[blk*BLOCK_SIZE+i] & b[blk*BLOCK_SIZE+i]) | (prop_s & blk_carry_s);
        prop_all_s  = prop_all_s & prop_s;
      end
      carry_s = prop_all_s ? carry_s : blk_carry_s;
    end
    cout = carry_s;
  end
endmodule

module mp_add_sequencer #(
  parameter int WIDTH      = 64,
  parameter int SLICE      = 16,
  parameter int BLOCK_SIZE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int N  = WIDTH / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_ZERO = KW'(0);
  localparam logic [KW-1:0] K_ONE  = KW'(1);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_eff_r;
  logic               carry_r;
  logic [KW-1:0]      k_r;
  logic [WIDTH-1:0]   sum_r;
  logic               cout_r;
  logic               ovf_r;
  logic               out_valid_r;
  logic               in_ready_r;
  logic               busy_r;

  logic [31:0]        off_s;
  logic [SLICE-1:0]   slice_a_s;
  logic [SLICE-1:0]   slice_b_s;
  logic [SLICE-1:0]   slice_sum_s;
  logic               slice_cout_s;

  // Bit offset of the slice currently being processed.
  assign off_s     = 32'(k_r) * 32'(SLICE);
  assign slice_a_s = a_r[off_s +: SLICE];
  assign slice_b_s = b_eff_r[off_s +: SLICE];

  CarrySkipModule #(
    .OPERAND_SIZE (SLICE),
    .BLOCK_SIZE   (BLOCK_SIZE)
  ) u_slice_adder (
    .a    (slice_a_s),
    .b    (slice_b_s),
    .cin  (carry_r),
    .sum  (slice_sum_s),
    .cout (slice_cout_s)
  );

  // Sequencer FSM: accept, walk the slices LSB first, then hold the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      a_r         <= {WIDTH{1'b0}};
      b_eff_r     <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      k_r         <= K_ZERO;
      sum_r       <= {WIDTH{1'b0}};
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            a_r        <= a;
            // Subtraction is a + ~b + 1; cin is ignored for sub.
            b_eff_r    <= sub ? ~b : b;
            carry_r    <= sub ? 1'b1 : cin;
            k_r        <= K_ZERO;
            state_r    <= RUN;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end else begin
            state_r    <= IDLE;
          end
        end
        RUN: begin
          sum_r[off_s +: SLICE] <= slice_sum_s;
          carry_r               <= slice_cout_s;
          if (k_r == K_LAST) begin
            state_r     <= DONE;
            k_r         <= K_ZERO;
            cout_r      <= slice_cout_s;
            // The top slice's sum MSB is the final result MSB.
            ovf_r       <= (a_r[WIDTH-1] == b_eff_r[WIDTH-1]) &&
                           (slice_sum_s[SLICE-1] != a_r[WIDTH-1]);
            out_valid_r <= 1'b1;
          end else begin
            k_r         <= k_r + K_ONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
          end else begin
            state_r     <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          k_r         <= K_ZERO;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;
  assign busy      = busy_r;
endmodule

// File: doc/mp_add_sequencer.md
MP_ADD_SEQUENCER -- requirements
Module: mp_add_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, meaning total operand width in bits; it SHALL be a multiple of SLICE.
REQ-002 The block SHALL have parameter SLICE, default 16, meaning the width of the internal adder slice processed per cycle.
REQ-003 The block SHALL have parameter BLOCK_SIZE, default 4, meaning the skip-block size passed to the slice adder.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the request carries a valid operand set.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-008 The block SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-009 The block SHALL have port cin, input, 1 bit: carry-in, used for add only.
REQ-010 The block SHALL have port sub, input, 1 bit: 1 selects a - b.
REQ-011 The block SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 The block SHALL have port sum, output, WIDTH bits: the result.
REQ-014 The block SHALL have port cout, output, 1 bit: carry out of the MSB (for sub, 1 = no borrow).
REQ-015 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.
REQ-016 The block SHALL have port busy, output, 1 bit: asserted in any state other than IDLE.

Function
REQ-017 The block SHALL instantiate exactly one CarrySkipModule with OPERAND_SIZE=SLICE and BLOCK_SIZE=BLOCK_SIZE, and time-multiplex it across N = WIDTH/SLICE slices.
REQ-018 The FSM SHALL have three states, IDLE, RUN and DONE, with in_ready = 1 only in IDLE.
REQ-019 A handshake SHALL occur on an edge where in_valid && in_ready; on it the block SHALL register a, b_eff = sub ? ~b : b, carry = sub ? 1 : cin, slice index k = 0, and enter RUN.
REQ-020 Each RUN cycle SHALL apply slice k of a and b_eff plus carry to the adder; at the edge it SHALL store the adder sum into sum[k*SLICE +: SLICE], load carry with the adder Cout, and increment k.
REQ-021 After the edge processing k = N-1, the block SHALL enter DONE with cout = final carry and ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
REQ-022 Latency SHALL be fixed: with the accept on edge 0, out_valid SHALL be high after edge N (edge 4 for defaults), independent of the data.
REQ-023 In DONE, out_valid SHALL be 1, and sum, cout and ovf SHALL be held stable until the edge where out_ready = 1; on that edge the FSM SHALL return to IDLE.
REQ-024 Throughput SHALL be one operation per N+2 cycles with out_ready tied high; in_ready SHALL be 0 in DONE, even when out_ready = 1.
REQ-025 Input changes outside the accept edge SHALL have no effect on an operation in flight.
REQ-026 For WIDTH == SLICE, RUN SHALL last exactly one cycle.
REQ-027 In_valid asserted in RUN or DONE SHALL be ignored; the requester must hold the request until in_ready.
REQ-028 For sub = 1, the cin input SHALL be ignored.

Reset
REQ-029 When rst_n = 0 at a rising edge, the block SHALL enter IDLE with k = 0, sum = 0, cout = 0, ovf = 0, out_valid = 0, busy = 0 and in_ready = 1 after the edge, regardless of the current state.
REQ-030 A reset asserted mid-RUN or mid-DONE SHALL discard the operation; no out_valid pulse SHALL follow.
REQ-031 in_valid SHALL be ignored while rst_n = 0.

Verification
REQ-032 The bench SHALL apply add a = 0xFFFF_FFFF_FFFF_FFFF, b = 1, cin = 0 -> sum = 0, cout = 1, ovf = 0, with out_valid high exactly 4 edges after accept.
REQ-033 The bench SHALL apply add a = 0x0000_0000_0000_FFFF, b = 1, cin = 0 -> sum = 0x0000_0000_0001_0000, cout = 0, proving carry across a slice boundary.
REQ-034 The bench SHALL apply sub a = 5, b = 7 -> sum = 0xFFFF_FFFF_FFFF_FFFE, cout = 0, ovf = 0; and sub a = 7, b = 5 -> sum = 2, cout = 1.
REQ-035 The bench SHALL apply add a = 0x7FFF_FFFF_FFFF_FFFF, b = 1 -> sum = 0x8000_0000_0000_0000, ovf = 1, cout = 0.
REQ-036 The bench SHALL hold out_ready = 0 for 3 cycles in DONE while changing a and b -> sum is held, in_ready = 0, and return to IDLE on the cycle after out_ready = 1.
REQ-037 The bench SHALL drop rst_n = 0 for one edge at RUN k = 2 -> IDLE with all outputs 0 and in_ready = 1; the next request completes normally with correct results.
